// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative floating-point divider, restoring radix-2.
// Operands use {sign, expo, mant} packing.
// Optional feature macro: FP_DIV_SUBNORM_EN.
//   Defined   - subnormal inputs are normalized in NORM, and tiny results are
//               denormalized with sticky before rounding.
//   Undefined - subnormal inputs read as signed zero, and tiny results flush
//               to signed zero with UF and NX set.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// NORM  | build significands and the biased exponent, load the iteration counter
// ITER  | one restoring quotient bit per cycle, MANT_W+3 cycles
// ROUND | normalize, round, and detect overflow/underflow
// DONE  | result presented until out_ready
module fp_div_iter #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] a,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] b,
    input  logic [1:0]                      rnd,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] res,
    output logic [4:0]                      status
);
    localparam int W  = SIGN_W + EXPO_W + MANT_W;
    localparam int QW = MANT_W + 3;
    localparam int EW = EXPO_W + 2;
    localparam int CW = $clog2(QW);

    localparam logic [EXPO_W-1:0]    EXP_ONES = '1;
    localparam logic signed [EW-1:0] E_ONE    = EW'(1);
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXPO_W - 1)) - 1);

    typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} state_t;
    state_t state, state_nx;

    // Live operand fields, only used on the accepting edge
    logic              a_sign, b_sign;
    logic [EXPO_W-1:0] a_expo, b_expo;
    logic [MANT_W-1:0] a_frac, b_frac;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic [W-1:0]      sp_res;
    logic [4:0]        sp_status;

    // Captured operation
    logic              sign_r;
    logic [1:0]        rnd_r;
    logic [EXPO_W-1:0] ea_r, eb_r;
    logic [MANT_W-1:0] fa_r, fb_r;

    // Iteration datapath
    logic [MANT_W:0]        div_r;
    logic [QW-1:0]          rem_r, q_r, div_ext, rem_sel, rem_nx;
    logic                   rem_ge;
    logic signed [EW-1:0]   exp_r;
    logic [CW-1:0]          cnt_r;

    logic [MANT_W:0]        norm_ma, norm_mb;
    logic signed [EW-1:0]   norm_ea, norm_eb;

    // Rounding datapath
    logic [QW-1:0]          q_n;
    logic signed [EW-1:0]   e_n, e_base, e_fin;
    logic [MANT_W:0]        sig;
    logic [MANT_W+1:0]      rounded;
    logic                   g_bit, r_bit, s_bit, up, inexact, tiny, ovf, to_inf;
    logic [W-1:0]           rnd_res;
    logic [4:0]             rnd_status;

    logic [W-1:0]           res_r;
    logic [4:0]             status_r;

`ifdef FP_DIV_SUBNORM_EN
    int                     lz_a, lz_b, sh;
    logic [QW-1:0]          q_sh;
    logic                   lost;

    function automatic int lzc(input logic [MANT_W:0] v);
        int n;
        n = MANT_W + 1;
        for (int i = 0; i <= MANT_W; i++) begin
            if (v[i]) n = MANT_W - i;
        end
        return n;
    endfunction
`endif

    assign a_sign = a[W-1];
    assign b_sign = b[W-1];
    assign a_expo = a[MANT_W +: EXPO_W];
    assign b_expo = b[MANT_W +: EXPO_W];
    assign a_frac = a[MANT_W-1:0];
    assign b_frac = b[MANT_W-1:0];

    assign a_nan  = (a_expo == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_expo == EXP_ONES) && (b_frac != '0);
    assign a_inf  = (a_expo == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_expo == EXP_ONES) && (b_frac == '0);
`ifdef FP_DIV_SUBNORM_EN
    assign a_zero = (a_expo == '0) && (a_frac == '0);
    assign b_zero = (b_expo == '0) && (b_frac == '0);
`else
    assign a_zero = (a_expo == '0);
    assign b_zero = (b_expo == '0);
`endif
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign res       = res_r;
    assign status    = status_r;

    // Result of a special-operand division, resolved straight from the live inputs
    always_comb begin
        sp_res    = '0;
        sp_status = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res    = {{SIGN_W{1'b0}}, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
            sp_status = 5'b10000;
        end else if (a_inf) begin
            sp_res = {SIGN_W'(a_sign ^ b_sign), EXP_ONES, {MANT_W{1'b0}}};
        end else if (b_zero) begin
            sp_res    = {SIGN_W'(a_sign ^ b_sign), EXP_ONES, {MANT_W{1'b0}}};
            sp_status = 5'b01000;
        end else begin
            sp_res = {SIGN_W'(a_sign ^ b_sign), {(EXPO_W+MANT_W){1'b0}}};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = special ? DONE : NORM;
            NORM:    state_nx = ITER;
            ITER:    if (cnt_r == '0) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Significands with hidden bit and unbiased-aligned exponents
    always_comb begin
        norm_ma = {1'b1, fa_r};
        norm_mb = {1'b1, fb_r};
        norm_ea = $signed({2'b00, ea_r});
        norm_eb = $signed({2'b00, eb_r});
`ifdef FP_DIV_SUBNORM_EN
        lz_a = lzc({1'b0, fa_r});
        lz_b = lzc({1'b0, fb_r});
        if (ea_r == '0) begin
            norm_ma = {1'b0, fa_r} << lz_a;
            norm_ea = E_ONE - EW'(lz_a);
        end
        if (eb_r == '0) begin
            norm_mb = {1'b0, fb_r} << lz_b;
            norm_eb = E_ONE - EW'(lz_b);
        end
`endif
    end

    // One restoring step: subtract when the divisor fits, then shift
    assign div_ext = {2'b00, div_r};
    assign rem_ge  = (rem_r >= div_ext);
    assign rem_sel = rem_ge ? (rem_r - div_ext) : rem_r;
    assign rem_nx  = rem_sel << 1;

    // Normalize, round and classify the iterated quotient
    always_comb begin
        q_n = q_r;
        e_n = exp_r;
        if (!q_r[QW-1]) begin
            q_n = {q_r[QW-2:0], 1'b0};
            e_n = exp_r - E_ONE;
        end
        s_bit  = |rem_r;
        tiny   = e_n[EW-1] || (e_n == '0);
        e_base = e_n - E_ONE;
`ifdef FP_DIV_SUBNORM_EN
        sh   = 0;
        q_sh = q_n;
        lost = 1'b0;
        if (tiny) begin
            sh = 1 - int'(e_n);
            if (sh > QW) sh = QW;
            for (int i = 0; i < QW; i++) begin
                if (i < sh) lost = lost | q_n[i];
            end
            q_sh   = q_n >> sh;
            e_base = '0;
        end
        q_n   = q_sh;
        s_bit = s_bit | lost;
`endif
        sig     = q_n[QW-1:2];
        g_bit   = q_n[1];
        r_bit   = q_n[0];
        inexact = g_bit | r_bit | s_bit;
        case (rnd_r)
            2'b00:   up = g_bit & (r_bit | s_bit | sig[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = sign_r & inexact;
            default: up = ~sign_r & inexact;
        endcase
        rounded = {1'b0, sig} + {{(MANT_W+1){1'b0}}, up};
        // Top two bits of the rounded significand: 01 normal, 10 carried out,
        // 00/01 for a denormalized value; added to (exponent - 1) they give the field.
        e_fin  = e_base + {{(EW-2){1'b0}}, rounded[MANT_W+1:MANT_W]};
        ovf    = ~e_fin[EW-1] && (e_fin[EW-2:0] >= {1'b0, EXP_ONES});
        to_inf = (rnd_r == 2'b00) || (rnd_r == 2'b11 && !sign_r) || (rnd_r == 2'b10 && sign_r);

        rnd_res    = {SIGN_W'(sign_r), e_fin[EXPO_W-1:0], rounded[MANT_W-1:0]};
        rnd_status = {4'b0000, inexact};
        if (ovf) begin
            rnd_status = 5'b00101;
            if (to_inf) rnd_res = {SIGN_W'(sign_r), EXP_ONES, {MANT_W{1'b0}}};
            else        rnd_res = {SIGN_W'(sign_r), {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
        end else if (tiny) begin
`ifdef FP_DIV_SUBNORM_EN
            rnd_status = {3'b000, inexact, inexact};
`else
            rnd_res    = {SIGN_W'(sign_r), {(EXPO_W+MANT_W){1'b0}}};
            rnd_status = 5'b00011;
`endif
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r   <= 1'b0;
            rnd_r    <= 2'b00;
            ea_r     <= '0;
            eb_r     <= '0;
            fa_r     <= '0;
            fb_r     <= '0;
            div_r    <= '0;
            rem_r    <= '0;
            q_r      <= '0;
            exp_r    <= '0;
            cnt_r    <= '0;
            res_r    <= '0;
            status_r <= 5'b00000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= a_sign ^ b_sign;
                        rnd_r  <= rnd;
                        ea_r   <= a_expo;
                        eb_r   <= b_expo;
                        fa_r   <= a_frac;
                        fb_r   <= b_frac;
                        if (special) begin
                            res_r    <= sp_res;
                            status_r <= sp_status;
                        end
                    end
                end
                NORM: begin
                    rem_r <= {2'b00, norm_ma};
                    div_r <= norm_mb;
                    exp_r <= norm_ea - norm_eb + BIAS;
                    q_r   <= '0;
                    cnt_r <= CW'(MANT_W + 2);
                end
                ITER: begin
                    rem_r <= rem_nx;
                    q_r   <= {q_r[QW-2:0], rem_ge};
                    if (cnt_r != '0) cnt_r <= cnt_r - 1'b1;
                end
                ROUND: begin
                    res_r    <= rnd_res;
                    status_r <= rnd_status;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_iter.sv
`timescale 1ns/1ps
module tb_fp_div_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  rnd = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res;
    logic [4:0]  status;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
        logic [31:0] res;
        logic [4:0]  st;
    } vec_t;

    always #5 clk = ~clk;

    fp_div_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .status(status)
    );

    // Drive one operand pair, scramble the inputs right after acceptance,
    // and count edges after the accepting edge until out_valid (bounded).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [1:0] tr,
                          input bit release_out, output logic [31:0] r, output logic [4:0] st,
                          output int lat);
        @(negedge clk);
        a = ta; b = tbv; rnd = tr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'h7FC00000; b = 32'h00000000; rnd = ~tr;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res; st = status;
        if (release_out) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h want 00000000", res); end
        checks++; if (status !== 5'h0) begin errors++; $display("FAIL reset_status: got %h want 00", status); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        vec_t v[4];
        logic [31:0] r; logic [4:0] st; int lat;
        v[0] = '{32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 5'h00};
        v[1] = '{32'hC0C00000, 32'h40000000, 2'b00, 32'hC0400000, 5'h00};
        v[2] = '{32'h3F800000, 32'h3F800000, 2'b01, 32'h3F800000, 5'h00};
        v[3] = '{32'h7F000000, 32'h3F800000, 2'b00, 32'h7F000000, 5'h00};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].a, v[i].b, v[i].rnd, 1'b1, r, st, lat);
            checks++; if (r !== v[i].res) begin errors++; $display("FAIL basic_res[%0d]: got %h want %h", i, r, v[i].res); end
            checks++; if (st !== v[i].st) begin errors++; $display("FAIL basic_status[%0d]: got %h want %h", i, st, v[i].st); end
            checks++; if (lat != 28) begin errors++; $display("FAIL basic_latency[%0d]: got %0d edges want 28", i, lat); end
        end
    endtask

    task automatic test_rounding();
        vec_t v[7];
        logic [31:0] r; logic [4:0] st; int lat;
        v[0] = '{32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 5'h01};
        v[1] = '{32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 5'h01};
        v[2] = '{32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAA, 5'h01};
        v[3] = '{32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAB, 5'h01};
        v[4] = '{32'hBF800000, 32'h40400000, 2'b10, 32'hBEAAAAAB, 5'h01};
        v[5] = '{32'hBF800000, 32'h40400000, 2'b11, 32'hBEAAAAAA, 5'h01};
        v[6] = '{32'hBF800000, 32'h40400000, 2'b01, 32'hBEAAAAAA, 5'h01};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].a, v[i].b, v[i].rnd, 1'b1, r, st, lat);
            checks++; if (r !== v[i].res) begin errors++; $display("FAIL round_res[%0d]: got %h want %h", i, r, v[i].res); end
            checks++; if (st !== v[i].st) begin errors++; $display("FAIL round_status[%0d]: got %h want %h", i, st, v[i].st); end
        end
    endtask

    // Special operands complete on the accepting edge itself: out_valid is
    // already high at the first sample after it.
    task automatic test_special();
        vec_t v[10];
        logic [31:0] r; logic [4:0] st; int lat;
        v[0] = '{32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, 5'h08};
        v[1] = '{32'h00000000, 32'h00000000, 2'b00, 32'h7FC00000, 5'h10};
        v[2] = '{32'hBF800000, 32'h00000000, 2'b00, 32'hFF800000, 5'h08};
        v[3] = '{32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, 5'h10};
        v[4] = '{32'hFFC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 5'h10};
        v[5] = '{32'h7F800000, 32'hC0000000, 2'b00, 32'hFF800000, 5'h00};
        v[6] = '{32'h40000000, 32'hFF800000, 2'b00, 32'h80000000, 5'h00};
        v[7] = '{32'h80000000, 32'h40400000, 2'b00, 32'h80000000, 5'h00};
        v[8] = '{32'h00400000, 32'h3F800000, 2'b00, 32'h00000000, 5'h00};
        v[9] = '{32'h3F800000, 32'h00000001, 2'b00, 32'h7F800000, 5'h08};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].a, v[i].b, v[i].rnd, 1'b1, r, st, lat);
            checks++; if (r !== v[i].res) begin errors++; $display("FAIL special_res[%0d]: got %h want %h", i, r, v[i].res); end
            checks++; if (st !== v[i].st) begin errors++; $display("FAIL special_status[%0d]: got %h want %h", i, st, v[i].st); end
            checks++; if (lat != 0) begin errors++; $display("FAIL special_latency[%0d]: got %0d extra edges want 0", i, lat); end
        end
    endtask

    task automatic test_overflow();
        vec_t v[6];
        logic [31:0] r; logic [4:0] st; int lat;
        v[0] = '{32'h7F7FFFFF, 32'h3F000000, 2'b00, 32'h7F800000, 5'h05};
        v[1] = '{32'h7F7FFFFF, 32'h3F000000, 2'b01, 32'h7F7FFFFF, 5'h05};
        v[2] = '{32'h7F7FFFFF, 32'h3F000000, 2'b10, 32'h7F7FFFFF, 5'h05};
        v[3] = '{32'h7F7FFFFF, 32'h3F000000, 2'b11, 32'h7F800000, 5'h05};
        v[4] = '{32'hFF7FFFFF, 32'h3F000000, 2'b10, 32'hFF800000, 5'h05};
        v[5] = '{32'hFF7FFFFF, 32'h3F000000, 2'b11, 32'hFF7FFFFF, 5'h05};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].rnd, 1'b1, r, st, lat);
            checks++; if (r !== v[i].res) begin errors++; $display("FAIL ovf_res[%0d]: got %h want %h", i, r, v[i].res); end
            checks++; if (st !== v[i].st) begin errors++; $display("FAIL ovf_status[%0d]: got %h want %h", i, st, v[i].st); end
        end
    endtask

    task automatic test_underflow();
        vec_t v[3];
        logic [31:0] r; logic [4:0] st; int lat;
        v[0] = '{32'h00800000, 32'h40000000, 2'b00, 32'h00000000, 5'h03};
        v[1] = '{32'h80800000, 32'h40000000, 2'b00, 32'h80000000, 5'h03};
        v[2] = '{32'h00800000, 32'h3F800000, 2'b00, 32'h00800000, 5'h00};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].a, v[i].b, v[i].rnd, 1'b1, r, st, lat);
            checks++; if (r !== v[i].res) begin errors++; $display("FAIL uf_res[%0d]: got %h want %h", i, r, v[i].res); end
            checks++; if (st !== v[i].st) begin errors++; $display("FAIL uf_status[%0d]: got %h want %h", i, st, v[i].st); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic [4:0] st; int lat;
        run_op(32'h40C00000, 32'h40000000, 2'b00, 1'b0, r, st, lat);
        checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL bp_res: got %h want 40400000", r); end
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (res !== 32'h40400000) begin errors++; $display("FAIL bp_hold_res[%0d]: got %h want 40400000", i, res); end
            checks++; if (status !== 5'h00) begin errors++; $display("FAIL bp_hold_status[%0d]: got %h want 00", i, status); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [4:0] st; int lat;
        bit seen;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; rnd = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got out_valid=1 want none"); end

        // Reset while the result is waiting in DONE
        run_op(32'h3F800000, 32'h40400000, 2'b00, 1'b0, r, st, lat);
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdone_out_valid: got %b want 0", out_valid); end
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL rstdone_res: got %h want 00000000", res); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstdone_stale: got out_valid=1 want none"); end

        run_op(32'h3F800000, 32'h3F800000, 2'b00, 1'b1, r, st, lat);
        checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL rst_recover_res: got %h want 3F800000", r); end
        checks++; if (lat != 28) begin errors++; $display("FAIL rst_recover_latency: got %0d edges want 28", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_special();
        test_overflow();
        test_underflow();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_div_iter.md
FP_DIV_ITER -- requirements
Module: fp_div_iter

Interface
REQ-001 The block SHALL take parameter SIGN_W, default 1, sign field width.
REQ-002 The block SHALL take parameter EXPO_W, default 8, exponent field width.
REQ-003 The block SHALL take parameter MANT_W, default 23, stored mantissa width; W = SIGN_W+EXPO_W+MANT_W.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  W  dividend, IEEE-754 style packing {sign, expo, mant}.
REQ-009 b  input  W  divisor, same packing.
REQ-010 rnd  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 res  output  W  quotient a/b.
REQ-014 status  output  5  flags {NV, DZ, OF, UF, NX}, bit 4 to bit 0.

Function
REQ-015 FSM states SHALL be IDLE, NORM, ITER, ROUND, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on an edge with in_valid=1 in IDLE; a, b and rnd SHALL be captured then, and later input changes SHALL be ignored.
REQ-017 Special operands (NaN, inf, zero in either operand) SHALL go IDLE->DONE in 1 cycle; no iterations.
REQ-018 Special results: NaN operand, 0/0 or inf/inf -> canonical qNaN {0, all-ones expo, mant MSB=1}, NV=1; finite nonzero/0 -> signed inf, DZ=1; inf/finite -> signed inf; finite/inf -> signed zero; 0/nonzero -> signed zero; all other flags 0.
REQ-019 Result sign SHALL be a_sign XOR b_sign, except for NaN results.
REQ-020 Normal path SHALL be IDLE->NORM (1 cycle)->ITER->ROUND (1 cycle)->DONE.
REQ-021 ITER SHALL be restoring radix-2, one quotient bit per cycle, exactly MANT_W+3 cycles (counter from MANT_W+2 down to 0); the remainder SHALL be MANT_W+3 bits wide.
REQ-022 Sticky SHALL be the OR of the final remainder bits.
REQ-023 Exponent SHALL be computed as ea-eb+bias at EXPO_W+2-bit signed width.
REQ-024 If the quotient MSB is 0, the quotient SHALL be shifted left by 1 and the exponent decremented before rounding.
REQ-025 ROUND SHALL apply rnd using guard/round/sticky; mantissa carry-out SHALL increment the exponent.
REQ-026 Overflow handling:
- Biased exponent >= all-ones SHALL give OF=1 and NX=1.
- Result SHALL be inf for RNE, and for RUP/RDN with matching sign.
- Otherwise the result SHALL be max finite.
REQ-027 NX SHALL be set when any discarded bit is nonzero.
REQ-028 Normal-path latency SHALL be fixed at MANT_W+5 edges from acceptance to out_valid=1.
REQ-029 DONE SHALL hold out_valid, res and status stable until an edge with out_ready=1, then SHALL return to IDLE.
REQ-030 in_ready SHALL be 0 in DONE, so no new operands are accepted that cycle.

Reset
REQ-031 While rst=1: state IDLE, in_ready=1, out_valid=0, res=0, status=0, counter=0, datapath registers 0.
REQ-032 Reset asserted mid-ITER or in DONE SHALL discard the operation; no out_valid SHALL follow reset release without a new acceptance.

Configuration
REQ-033 Macro FP_DIV_SUBNORM_EN defined:
- NORM SHALL left-normalize subnormal mantissas via leading-zero count and adjust the exponents.
- Tiny results SHALL be right-shifted with sticky before rounding to produce subnormals.
- UF SHALL be set if the result is tiny and inexact.
REQ-034 Macro FP_DIV_SUBNORM_EN undefined:
- Subnormal inputs SHALL be treated as signed zero.
- Tiny results SHALL flush to signed zero with UF=1, NX=1.
- NORM SHALL remain a 1-cycle pass-through so latency is unchanged.

Verification
REQ-035 a=0x40C00000, b=0x40000000, rnd=00 -> res=0x40400000, status=0, out_valid exactly 28 edges after acceptance.
REQ-036 Rounding of a=0x3F800000, b=0x40400000:
- rnd=00 -> res=0x3EAAAAAB, status=0x01.
- rnd=01 -> res=0x3EAAAAAA, status=0x01.
REQ-037 Special operands:
- a=0x3F800000, b=0x00000000 -> res=0x7F800000, status=0x08, out_valid 1 edge after acceptance.
- a=b=0x00000000 -> res=0x7FC00000, status=0x10.
REQ-038 a=0x7F7FFFFF, b=0x3F000000:
- rnd=00 -> res=0x7F800000, status=0x05.
- rnd=01 -> res=0x7F7FFFFF, status=0x05.
REQ-039 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> res, status and out_valid stable, in_ready=0; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-040 Reset mid-operation: assert rst during ITER cycle 5 -> out_valid=0, in_ready=1 immediately; no stale result after release.
